// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MADDR  = 4'd3,
      ST_MRD    = 4'd4,
      ST_MWB    = 4'd5,
      ST_MWR    = 4'd6,
      ST_REXE   = 4'd7,
      ST_RWB    = 4'd8,
      ST_IEXE   = 4'd9,
      ST_IWB    = 4'd10,
      ST_BRN    = 4'd11,
      ST_JMP    = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_FUNCT = 3'b010
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      SRCB_REG    = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } srcb_e;

   typedef struct packed {
      logic    mem_rd;
      logic    mem_wrt;
      logic    iord;
      logic    pc_wrt;
      logic    pc_wrt_cond;
      pc_src_e pc_src;
      logic    alu_src_a;
      srcb_e   alu_src_b;
      alu_op_e alu_op;
      logic    reg_dst;
      logic    reg_wrt;
      logic    mem_to_reg;
   } ctrl_t;

   // Moore control word for a state; FETCH write strobes are added by the done term.
   function automatic ctrl_t decode_ctrl(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.mem_rd    = 1'b1;
            c.alu_src_b = SRCB_FOUR;
         end
         ST_DECODE: c.alu_src_b = SRCB_IMM_SH;
         ST_MADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         ST_MRD: begin
            c.mem_rd = 1'b1;
            c.iord   = 1'b1;
         end
         ST_MWB: begin
            c.reg_wrt    = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         ST_MWR: begin
            c.mem_wrt = 1'b1;
            c.iord    = 1'b1;
         end
         ST_REXE: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         ST_RWB: begin
            c.reg_wrt = 1'b1;
            c.reg_dst = 1'b1;
         end
         ST_IEXE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         ST_IWB: c.reg_wrt = 1'b1;
         ST_BRN: begin
            c.alu_src_a   = 1'b1;
            c.alu_op      = ALU_SUB;
            c.pc_wrt_cond = 1'b1;
            c.pc_src      = PC_ALUOUT;
         end
         ST_JMP: begin
            c.pc_wrt = 1'b1;
            c.pc_src = PC_JUMP;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic is_mem_state(state_e s);
      return (s == ST_FETCH) || (s == ST_MRD) || (s == ST_MWR);
   endfunction

   function automatic logic op_legal(logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait counter: completion (handshake or fixed latency) and handshake timeout.
module mem_wait_ctr #(
   parameter bit          MEM_HS  = 1'b1,
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned MEM_TMO = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic mem_ready,
   output logic done_c,
   output logic tmo_c
);

   localparam int unsigned CNT_MAX = (MEM_LAT > MEM_TMO) ? MEM_LAT : MEM_TMO;
   localparam int unsigned CTR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   logic [CTR_W-1:0] ctr;
   logic             lat_hit_c;
   logic             tmo_hit_c;

   assign lat_hit_c = (ctr == CTR_W'(MEM_LAT - 1));
   assign tmo_hit_c = (ctr == CTR_W'(MEM_TMO - 1));

   assign done_c = active && (MEM_HS ? mem_ready : lat_hit_c);
   assign tmo_c  = active && MEM_HS && !mem_ready && tmo_hit_c;

   // Counts wait cycles within one memory state; returns to zero when the state is left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr <= '0;
      end else if (active && !done_c && !tmo_c) begin
         ctr <= ctr + CTR_W'(1);
      end else begin
         ctr <= '0;
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the 32-bit MIPS core (FETCH/DECODE/EXEC/MEM/WB sequencing).
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter bit          MEM_HS  = 1'b1,
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned MEM_TMO = 64,
   parameter int unsigned RET_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_rd,
   output logic             mem_wrt,
   output logic             iord,
   output logic             ir_wrt,
   output logic             pc_wrt,
   output logic             pc_wrt_cond,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             reg_dst,
   output logic             reg_wrt,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic             mem_err,
   output logic [RET_W-1:0] retired
);

   state_e state;
   state_e state_nx;
   ctrl_t  ctrl_q;
   logic   mem_act_c;
   logic   done_c;
   logic   tmo_c;
   logic   fetch_done_c;
   logic   retire_c;
   logic   unused_zero_c;

   // The branch condition is applied in the datapath through pc_wrt_cond.
   assign unused_zero_c = zero;

   assign mem_act_c = is_mem_state(state);

   mem_wait_ctr #(
      .MEM_HS  (MEM_HS),
      .MEM_LAT (MEM_LAT),
      .MEM_TMO (MEM_TMO)
   ) u_wait (
      .clk       (clk),
      .rst       (rst),
      .active    (mem_act_c),
      .mem_ready (mem_ready),
      .done_c    (done_c),
      .tmo_c     (tmo_c)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (!mem_err) state_nx = ST_FETCH;
         ST_FETCH: begin
            if (tmo_c)       state_nx = ST_IDLE;
            else if (done_c) state_nx = ST_DECODE;
         end
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_nx = ST_REXE;
               OP_LW, OP_SW: state_nx = ST_MADDR;
               OP_BEQ:       state_nx = ST_BRN;
               OP_J:         state_nx = ST_JMP;
               OP_ADDI:      state_nx = ST_IEXE;
               default:      state_nx = ST_FETCH;
            endcase
         end
         ST_MADDR:  state_nx = (opcode == OP_LW) ? ST_MRD : ST_MWR;
         ST_MRD: begin
            if (tmo_c)       state_nx = ST_IDLE;
            else if (done_c) state_nx = ST_MWB;
         end
         ST_MWR: begin
            if (tmo_c)       state_nx = ST_IDLE;
            else if (done_c) state_nx = ST_FETCH;
         end
         ST_REXE:   state_nx = ST_RWB;
         ST_IEXE:   state_nx = ST_IWB;
         ST_MWB, ST_RWB, ST_IWB, ST_BRN, ST_JMP: state_nx = ST_FETCH;
         default:   state_nx = ST_IDLE;
      endcase
   end

   assign fetch_done_c = (state == ST_FETCH) && done_c;
   assign retire_c     = (state == ST_MWB) || (state == ST_RWB) || (state == ST_IWB) ||
                         (state == ST_BRN) || (state == ST_JMP) ||
                         ((state == ST_MWR) && done_c);

   // Control word is registered from the next state so it lines up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ctrl_q  <= '0;
         mem_err <= 1'b0;
         retired <= '0;
      end else begin
         state  <= state_nx;
         ctrl_q <= decode_ctrl(state_nx);
         if (tmo_c)    mem_err <= 1'b1;
         if (retire_c) retired <= retired + RET_W'(1);
      end
   end

   assign mem_rd      = ctrl_q.mem_rd;
   assign mem_wrt     = ctrl_q.mem_wrt;
   assign iord        = ctrl_q.iord;
   assign ir_wrt      = fetch_done_c;
   assign pc_wrt      = ctrl_q.pc_wrt | fetch_done_c;
   assign pc_wrt_cond = ctrl_q.pc_wrt_cond;
   assign pc_src      = ctrl_q.pc_src;
   assign alu_src_a   = ctrl_q.alu_src_a;
   assign alu_src_b   = ctrl_q.alu_src_b;
   assign alu_op      = ctrl_q.alu_op;
   assign reg_dst     = ctrl_q.reg_dst;
   assign reg_wrt     = ctrl_q.reg_wrt;
   assign mem_to_reg  = ctrl_q.mem_to_reg;
   assign illegal     = (state == ST_DECODE) && !op_legal(opcode);

endmodule
